// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a priority pipeline write, a handshaked mult/div write and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr0_en,
  input  logic [ADDR_W-1:0]     wr0_addr,
  input  logic [DATA_W-1:0]     wr0_data,
  input  logic                  wr1_valid,
  output logic                  wr1_ready,
  input  logic [ADDR_W-1:0]     wr1_addr,
  input  logic [DATA_W-1:0]     wr1_data,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic                  sb_conflict
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              conf_q, conf_d;
  logic              wr0_act, wr1_act, rsv_act;
  assign wr1_ready   = ~wr0_en;
  assign wr0_act     = wr0_en && wr0_addr != '0;
  assign wr1_act     = wr1_valid && wr1_ready && wr1_addr != '0;
  assign rsv_act     = rsv_en && rsv_addr != '0;
  assign sb_conflict = conf_q;
  always_comb begin
    regs_d = regs_q;
    if (wr0_act) regs_d[wr0_addr] = wr0_data;
    else if (wr1_act) regs_d[wr1_addr] = wr1_data;
  end
  // clear first so a same-cycle reserve on the same register wins
  always_comb begin
    busy_d = busy_q;
    if (wr1_act) busy_d[wr1_addr] = 1'b0;
    if (rsv_act) busy_d[rsv_addr] = 1'b1;
  end
  assign conf_d = (rsv_act && busy_q[rsv_addr] && !(wr1_act && wr1_addr == rsv_addr)) ||
                  (wr0_act && busy_q[wr0_addr]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      conf_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      conf_q <= conf_d;
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra         = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_busy[k] = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
    assign rd_data[k*DATA_W +: DATA_W] = ra == '0 ? '0 :
                                         wr0_act && wr0_addr == ra ? wr0_data :
                                         wr1_act && wr1_addr == ra ? wr1_data : regs_q[ra];
`else
    assign rd_data[k*DATA_W +: DATA_W] = ra == '0 ? '0 : regs_q[ra];
`endif
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of reads, both write ports, scoreboard and conflict flag.
module tb_regfile_mp;
  logic        clk = 0, rst = 1;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr0_en = 0, wr1_valid = 0, wr1_ready, rsv_en = 0, sb_conflict;
  logic [4:0]  wr0_addr = '0, wr1_addr = '0, rsv_addr = '0;
  logic [31:0] wr0_data = '0, wr1_data = '0;
  int checks = 0, errors = 0;
  regfile_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .sb_conflict(sb_conflict)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask
  initial begin
    tick();
    tick();
    rst = 0;
    rd(5'd3, 5'd7);
    chk("reset_data0", rd_data[31:0], 32'h0);
    chk("reset_busy", {30'd0, rd_busy}, 32'h0);
    chk("reset_conflict", sb_conflict, 0);
    chk("reset_ready", wr1_ready, 1);
    // load r5, reserve r7, then async reset mid-cycle
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'h1234; rsv_en = 1; rsv_addr = 7;
    tick();
    wr0_en = 0; rsv_en = 0;
    rd(5'd5, 5'd7);
    chk("pre_rst_r5", rd_data[31:0], 32'h1234);
    chk("pre_rst_busy7", rd_busy[1], 1);
    #2 rst = 1;
    #1;
    chk("async_rst_r5", rd_data[31:0], 32'h0);
    chk("async_rst_busy7", rd_busy[1], 0);
    rst = 0;
    tick();
    chk("post_rst_conflict", sb_conflict, 0);
    // wr0 basic and r0 immunity
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'hDEADBEEF;
    tick();
    wr0_addr = 0; wr0_data = 32'hFFFFFFFF;
    rd(5'd3, 5'd3);
    chk("r3_port0", rd_data[31:0], 32'hDEADBEEF);
    chk("r3_port1", rd_data[63:32], 32'hDEADBEEF);
    tick();
    wr0_en = 0;
    rd(5'd0, 5'd3);
    chk("r0_port0", rd_data[31:0], 32'h0);
    chk("r3_hold", rd_data[63:32], 32'hDEADBEEF);
    // wr1 blocked by wr0, then accepted
    wr0_en = 1; wr0_addr = 2; wr0_data = 32'h22;
    wr1_valid = 1; wr1_addr = 8; wr1_data = 32'hA5A5A5A5;
    #1;
    chk("wr1_ready_blocked", wr1_ready, 0);
    tick();
    wr0_en = 0;
    rd(5'd8, 5'd2);
    chk("r8_unchanged", rd_data[31:0], 32'h0);
    chk("r2_written", rd_data[63:32], 32'h22);
    chk("wr1_ready_free", wr1_ready, 1);
    tick();
    wr1_valid = 0;
    #1;
    chk("r8_written", rd_data[31:0], 32'hA5A5A5A5);
    // scoreboard set / clear / set-wins
    rsv_en = 1; rsv_addr = 9;
    tick();
    rsv_en = 0;
    rd(5'd9, 5'd8);
    chk("busy9_set", rd_busy[0], 1);
    chk("busy8_clear", rd_busy[1], 0);
    wr1_valid = 1; wr1_addr = 9; wr1_data = 32'h42;
    tick();
    wr1_valid = 0;
    #1;
    chk("busy9_cleared", rd_busy[0], 0);
    chk("r9_data", rd_data[31:0], 32'h42);
    chk("wr1_no_conflict", sb_conflict, 0);
    rsv_en = 1; wr1_valid = 1; wr1_data = 32'h99;
    tick();
    #1;
    chk("set_wins_busy", rd_busy[0], 1);
    chk("set_wins_data", rd_data[31:0], 32'h99);
    chk("set_wins_noconf", sb_conflict, 0);
    wr1_data = 32'h42;
    tick();
    rsv_en = 0; wr1_valid = 0;
    #1;
    chk("rsv_busy_being_cleared", sb_conflict, 0);
    chk("busy9_still", rd_busy[0], 1);
    chk("r9_data2", rd_data[31:0], 32'h42);
    // conflict flag
    rsv_en = 1; rsv_addr = 10;
    tick();
    chk("first_rsv_noconf", sb_conflict, 0);
    tick();
    rsv_en = 0;
    chk("double_rsv_conf", sb_conflict, 1);
    tick();
    chk("conf_one_cycle", sb_conflict, 0);
    wr0_en = 1; wr0_addr = 10; wr0_data = 32'h10;
    tick();
    wr0_en = 0;
    rd(5'd10, 5'd0);
    chk("waw_conf", sb_conflict, 1);
    chk("waw_busy_kept", rd_busy[0], 1);
    chk("waw_data", rd_data[31:0], 32'h10);
    rsv_en = 1; rsv_addr = 0;
    tick();
    rsv_en = 0;
    chk("rsv_r0_noconf", sb_conflict, 0);
    chk("rsv_r0_busy", rd_busy[1], 0);
    // same-cycle read of a write in progress
    wr0_en = 1; wr0_addr = 4; wr0_data = 32'h77;
    rd(5'd0, 5'd4);
`ifdef REGFILE_BYPASS_EN
    chk("wr0_bypass", rd_data[63:32], 32'h77);
`else
    chk("wr0_no_bypass", rd_data[63:32], 32'h0);
`endif
    tick();
    wr0_en = 0;
    chk("r4_next", rd_data[63:32], 32'h77);
    wr1_valid = 1; wr1_addr = 11; wr1_data = 32'h5;
    rd(5'd11, 5'd4);
`ifdef REGFILE_BYPASS_EN
    chk("wr1_bypass", rd_data[31:0], 32'h5);
`else
    chk("wr1_no_bypass", rd_data[31:0], 32'h0);
`endif
    tick();
    wr1_valid = 0;
    chk("r11_next", rd_data[31:0], 32'h5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file; successor to the single-write, two-read GPR file. Sits in ID/WB of the MIPS core:
- N combinational read ports.
- Pipeline writeback port (wr0).
- Handshaked long-latency writeback port (wr1) for the mult/div unit.
- Per-register busy scoreboard so ID can stall on pending mult/div results.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NRD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-high
rd_addr  in  NRD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
rd_data  out  NRD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
rd_busy  out  NRD  scoreboard busy bit of addressed register, per port
wr0_en  in  1  pipeline writeback enable
wr0_addr  in  ADDR_W  pipeline writeback address
wr0_data  in  DATA_W  pipeline writeback data
wr1_valid  in  1  mult/div writeback request
wr1_ready  out  1  wr1 accepted this cycle when valid&ready
wr1_addr  in  ADDR_W  mult/div writeback address
wr1_data  in  DATA_W  mult/div writeback data
rsv_en  in  1  reserve destination (mult/div issue)
rsv_addr  in  ADDR_W  register to mark busy
sb_conflict  out  1  registered one-cycle flag: reserve or wr0 write to an already-busy register

Behaviour:
- Reset (async, rst=1): all registers = 0, all busy bits = 0, sb_conflict = 0. Reset mid-transfer discards the pending wr1 beat; the producer re-presents it after reset.
- Register 0: reads always return 0; writes from either port are ignored; rsv_en to 0 is ignored and never sets busy or conflict.
- Reads: combinational, zero-latency, for each of the NRD ports independently.
- rd_busy[k] = busy[rd_addr[k]]; combinational, reflects registered state (no bypass of same-cycle set/clear).
- wr0 always has priority. wr1_ready = ~wr0_en (combinational), regardless of addresses.
  - A wr1 beat with wr1_valid=1 and wr1_ready=0 is held by the producer.
  - wr1_addr/wr1_data must stay stable until accepted.
- Write timing: an accepted write updates storage at the clock edge and is visible on reads from the next cycle (see optional feature for same-cycle forwarding).
- Scoreboard:
  - rsv_en sets busy[rsv_addr] at the edge.
  - An accepted wr1 clears busy[wr1_addr] at the edge.
  - Set and clear on the same address in the same cycle: set wins (busy stays 1).
  - A wr0 write never clears busy.
  - A wr1 write to a non-busy register is legal; data is written and busy stays 0.
- sb_conflict, registered next cycle, =1 if the previous cycle had either:
  - rsv_en to a nonzero register already busy and not being cleared that cycle; or
  - wr0_en to a nonzero busy register (WAW hazard).
  Otherwise 0. Storage behaviour is unaffected by a conflict.
- No storage update occurs without an enable; registers hold their value.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-to-read forwarding. If a read address matches an active write this cycle, rd_data returns the write data combinationally.
  - Applies to wr0 when wr0_en=1, and to wr1 when valid&ready.
  - Register 0 is excluded.
  - wr0 and wr1 never write in the same cycle (wr0 priority), so at most one source matches.
- Undefined: no forwarding; rd_data returns the stored value only. The new value appears on the cycle after the write.

Test Plan:
- Assert rst mid-cycle after loading r5=0x1234 and reserving r7 -> reads return 0 immediately (async) and rd_busy=0; sb_conflict=0 after release.
- wr0 writes r3=0xDEADBEEF; read r3 on ports 0 and 1 next cycle -> both 0xDEADBEEF; wr0 to r0 with 0xFFFFFFFF -> r0 reads 0.
- wr1_valid for r8=0xA5A5A5A5 while wr0_en=1 to r2 -> wr1_ready=0, r8 unchanged. Next cycle wr0_en=0 -> ready=1, r8=0xA5A5A5A5.
- rsv r9, then read r9 -> rd_busy=1. wr1 writes r9=0x42 -> busy clears next cycle. Same-cycle rsv r9 and wr1 r9 -> busy stays 1, data=0x42.
- Reserve r10 twice (second while busy) -> sb_conflict=1 for exactly one cycle. wr0 to busy r10 -> sb_conflict=1, busy stays 1.
- With REGFILE_BYPASS_EN: wr0 writes r4=0x77 while port 1 reads r4 -> rd_data=0x77 same cycle. Without the macro -> old value, then 0x77 next cycle.
